// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA 640x480@60 timing generator with a registered
// sync/colour output stage. A clock divider produces the pixel tick; the
// horizontal/line counters feed object blocks, whose hit flag and colour come
// back and are registered together with hsync/vsync so all three stay aligned.
module vga_timing_gen #(
  parameter int          CLK_DIV  = 4,
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_tick,
  output logic [9:0]  h_count,
  output logic [8:0]  v_count,
  output logic        video_on,
  output logic        frame_start,
  input  logic        square_on,
  input  logic [15:0] rgb_in,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Inclusive window test used for both sync pulses.
  function automatic logic in_window(input logic [9:0] val,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

  logic [3:0]  div_q, div_d;
  logic        tick_q, tick_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [15:0] rgb_q, rgb_d;

  assign pix_tick    = tick_q;
  assign h_count     = h_cnt_q;
  // Lines 512..524 alias onto 0..12; consumers qualify with video_on.
  assign v_count     = v_cnt_q[8:0];
  assign video_on    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign frame_start = tick_q && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb_out     = rgb_q;

  // Pixel divider and raster counters; the tick is registered so that it is
  // low during reset and, for CLK_DIV=1, high on every cycle afterwards.
  always_comb begin
    div_d   = div_q;
    tick_d  = 1'b0;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (div_q == DIV_LAST) begin
      div_d = 4'd0;
    end else begin
      div_d = div_q + 4'd1;
    end
    tick_d = (div_d == DIV_LAST);
    if (tick_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = 10'd0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
      end
    end else begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
    end
  end

  // Output stage: sample the pre-increment counters on each tick so sync and
  // colour share one pixel period of latency; blanking forces black.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (tick_q) begin
      hsync_d = !in_window(h_cnt_q, HS_FIRST, HS_LAST);
      vsync_d = !in_window(v_cnt_q, VS_FIRST, VS_LAST);
      if (!video_on) begin
        rgb_d = 16'h0000;
      end else if (square_on) begin
        rgb_d = rgb_in;
      end else begin
        rgb_d = BG_COLOR;
      end
    end else begin
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      rgb_d   = rgb_q;
    end
  end

  // State registers with synchronous reset that wins over the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= 4'd0;
      tick_q  <= 1'b0;
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 16'h0000;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

endmodule
